// File: rtl/kdg_pkg.sv
// Shared types and default sizes for the key/debug gate.
package kdg_pkg;

   localparam int unsigned KeyWDefault  = 128;
   localparam int unsigned WordWDefault = 32;

   typedef enum logic [2:0] {
      StEmpty,
      StArmed,
      StWipe,
      StVerify,
      StDebug,
      StFault
   } kdg_state_e;

endpackage

// File: rtl/kdg_zeroizer.sv
// Word-serial key zeroizer: word counter, per-word clear, last-word flag and
// an all-zero compare of the key register owned by the parent.
// KEY_W must be an integer multiple of WORD_W.
module kdg_zeroizer
   import kdg_pkg::*;
#(
   parameter int unsigned KEY_W  = KeyWDefault,
   parameter int unsigned WORD_W = WordWDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wipe_en_i,
   input  logic [KEY_W-1:0] key_i,
   output logic [KEY_W-1:0] key_o,
   output logic             last_o,
   output logic             zero_o
);

   localparam int unsigned NWords = KEY_W / WORD_W;
   localparam int unsigned CntW   = (NWords > 1) ? $clog2(NWords) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign last_o = (cnt_q == CntW'(NWords - 1));
   assign zero_o = (key_i == '0);

   // Counter advances only while wiping and falls back to 0 otherwise, so every
   // wipe starts at word 0.
   always_comb begin
      cnt_d = '0;
      if (wipe_en_i && !last_o) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Word counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Next key value: the word selected by the counter is cleared while wiping.
   always_comb begin
      key_o = key_i;
      for (int unsigned w = 0; w < NWords; w++) begin
         if (wipe_en_i && (cnt_q == CntW'(w))) begin
            key_o[w*WORD_W +: WORD_W] = '0;
         end
      end
   end

endmodule

// File: rtl/key_debug_gate.sv
// Key/debug gate: holds a provisioned key and guarantees it is zeroized and
// verified clean before debug is granted.
// Optional macro KDG_AUTH_EN: debug entry additionally requires dbg_auth_ok.
module key_debug_gate
   import kdg_pkg::*;
#(
   parameter int unsigned KEY_W  = KeyWDefault,
   parameter int unsigned WORD_W = WordWDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_in,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic             dbg_req,
   input  logic             dbg_auth_ok,
   output logic [KEY_W-1:0] secret_key,
   output logic             debug_mode,
   output logic             key_live,
   output logic             wipe_busy,
   output logic             fault
);

   kdg_state_e       state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [KEY_W-1:0] key_wiped;
   logic             wipe_last;
   logic             key_zero;
   logic             dbg_go;

`ifdef KDG_AUTH_EN
   assign dbg_go = dbg_req & dbg_auth_ok;
`else
   logic unused_auth;
   assign unused_auth = dbg_auth_ok;
   assign dbg_go      = dbg_req;
`endif

   kdg_zeroizer #(
      .KEY_W  (KEY_W),
      .WORD_W (WORD_W)
   ) u_zeroizer (
      .clk       (clk),
      .rst       (rst),
      .wipe_en_i (state_q == StWipe),
      .key_i     (key_q),
      .key_o     (key_wiped),
      .last_o    (wipe_last),
      .zero_o    (key_zero)
   );

   // Next-state, key register update and all outputs.
   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      key_ready  = 1'b0;
      secret_key = '0;
      key_live   = 1'b0;
      wipe_busy  = 1'b0;
      debug_mode = 1'b0;
      fault      = 1'b0;

      unique case (state_q)
         StEmpty: begin
            key_ready = !dbg_go;
            // No key held, so debug needs no wipe.
            if (dbg_go) begin
               state_d = StDebug;
            end else if (key_valid) begin
               key_d   = key_in;
               state_d = StArmed;
            end
         end
         StArmed: begin
            key_ready  = !dbg_go;
            secret_key = key_q;
            key_live   = 1'b1;
            // Debug wins over a simultaneous key transfer.
            if (dbg_go) begin
               state_d = StWipe;
            end else if (key_valid) begin
               key_d = key_in;
            end
         end
         StWipe: begin
            wipe_busy = 1'b1;
            key_d     = key_wiped;
            if (wipe_last) begin
               state_d = StVerify;
            end
         end
         StVerify: begin
            wipe_busy = 1'b1;
            if (!key_zero) begin
               state_d = StFault;
            end else if (dbg_go) begin
               state_d = StDebug;
            end else begin
               state_d = StEmpty;
            end
         end
         StDebug: begin
            debug_mode = 1'b1;
            // Only the request level exits; auth dropping does not.
            if (!dbg_req) begin
               state_d = StEmpty;
            end
         end
         StFault: begin
            fault = 1'b1;
         end
         default: begin
            state_d = StFault;
         end
      endcase

      // Nothing is presented downstream while reset is held.
      if (rst) begin
         key_ready  = 1'b0;
         secret_key = '0;
         key_live   = 1'b0;
         wipe_busy  = 1'b0;
         debug_mode = 1'b0;
         fault      = 1'b0;
      end
   end

   // State and key registers; reset clears the whole key in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
      end
   end

endmodule

// File: tb/tb_key_debug_gate.sv
// Scoreboard bench for key_debug_gate: stimulus queues the expected outputs for
// each cycle, a negedge monitor pops and compares them.
module tb_key_debug_gate;

   localparam int unsigned KW = 128;

`ifdef KDG_AUTH_EN
   localparam bit AuthLvl = 1'b1;
`else
   localparam bit AuthLvl = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic [KW-1:0] key_in;
   logic          key_valid;
   logic          key_ready;
   logic          dbg_req;
   logic          dbg_auth_ok;
   logic [KW-1:0] secret_key;
   logic          debug_mode;
   logic          key_live;
   logic          wipe_busy;
   logic          fault;

   key_debug_gate #(
      .KEY_W  (KW),
      .WORD_W (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .dbg_req     (dbg_req),
      .dbg_auth_ok (dbg_auth_ok),
      .secret_key  (secret_key),
      .debug_mode  (debug_mode),
      .key_live    (key_live),
      .wipe_busy   (wipe_busy),
      .fault       (fault)
   );

   typedef struct {
      int            at_cyc;
      string         name;
      logic [KW-1:0] key;
      logic          rdy;
      logic          live;
      logic          busy;
      logic          dm;
      logic          flt;
   } exp_t;

   exp_t q[$];
   int   cyc     = 0;
   int   n_vec   = 0;
   int   n_miss  = 0;

   localparam logic [KW-1:0] K1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [KW-1:0] K2 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
   localparam logic [KW-1:0] K3 = 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C;
   localparam logic [KW-1:0] Z  = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: compare every queued expectation on the negedge of its cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].at_cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            if (e.at_cyc < cyc) begin
               n_miss++;
               $display("FAIL %s: check slot missed (cyc %0d, required %0d)", e.name, cyc,
                        e.at_cyc);
            end else if (secret_key !== e.key || key_ready !== e.rdy || key_live !== e.live ||
                         wipe_busy !== e.busy || debug_mode !== e.dm || fault !== e.flt) begin
               n_miss++;
               $display("FAIL %s cyc=%0d got key=%h rdy=%b live=%b busy=%b dbg=%b flt=%b required key=%h rdy=%b live=%b busy=%b dbg=%b flt=%b",
                        e.name, cyc, secret_key, key_ready, key_live, wipe_busy, debug_mode,
                        fault, e.key, e.rdy, e.live, e.busy, e.dm, e.flt);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue the expected outputs for the current cycle, then advance one clock.
   task automatic step(input string name, input logic [KW-1:0] k, input logic rdy,
                       input logic live, input logic busy, input logic dm);
      exp_t e;
      e.at_cyc = cyc;
      e.name   = name;
      e.key    = k;
      e.rdy    = rdy;
      e.live   = live;
      e.busy   = busy;
      e.dm     = dm;
      e.flt    = 1'b0;
      q.push_back(e);
      tick();
   endtask

   initial begin
      rst         = 1'b1;
      key_in      = '0;
      key_valid   = 1'b0;
      dbg_req     = 1'b0;
      dbg_auth_ok = AuthLvl;
      tick();
      tick();

      // Reset: all outputs low while rst is held, key_ready high right after.
      step("reset", Z, 0, 0, 0, 0);
      rst = 1'b0;
      step("empty", Z, 1, 0, 0, 0);

      // Load and overwrite.
      key_in = K1; key_valid = 1'b1;
      step("load", Z, 1, 0, 0, 0);
      key_valid = 1'b0;
      step("armed_k1", K1, 1, 1, 0, 0);
      key_in = K2; key_valid = 1'b1;
      step("overwrite", K1, 1, 1, 0, 0);
      key_valid = 1'b0;
      step("armed_k2", K2, 1, 1, 0, 0);

      // Collision: debug wins, K3 is not captured; held request reaches DEBUG at cycle 6.
      key_in = K3; key_valid = 1'b1; dbg_req = 1'b1;
      step("collide", K2, 0, 1, 0, 0);
      key_valid = 1'b0;
      for (int i = 1; i <= 4; i++) step($sformatf("wipe_c%0d", i), Z, 0, 0, 1, 0);
      step("verify_c5", Z, 0, 0, 1, 0);
      step("debug_c6", Z, 0, 0, 0, 1);
      step("debug_hold", Z, 0, 0, 0, 1);
      dbg_req = 1'b0;
      step("debug_drop", Z, 0, 0, 0, 1);
      step("debug_exit", Z, 1, 0, 0, 0);

      // Abort: 2-cycle pulse from ARMED, wipe completes to EMPTY, key not restored.
      key_in = K1; key_valid = 1'b1;
      step("ab_load", Z, 1, 0, 0, 0);
      key_valid = 1'b0;
      step("ab_armed", K1, 1, 1, 0, 0);
      dbg_req = 1'b1;
      step("ab_req", K1, 0, 1, 0, 0);
      step("ab_wipe1", Z, 0, 0, 1, 0);
      dbg_req = 1'b0;
      for (int i = 2; i <= 4; i++) step($sformatf("ab_wipe%0d", i), Z, 0, 0, 1, 0);
      step("ab_verify", Z, 0, 0, 1, 0);
      step("ab_empty", Z, 1, 0, 0, 0);
      key_in = K2; key_valid = 1'b1;
      step("ab_reload", Z, 1, 0, 0, 0);
      key_valid = 1'b0;
      step("ab_armed_k2", K2, 1, 1, 0, 0);

      // Reset at wipe cycle 2.
      dbg_req = 1'b1;
      step("rw_req", K2, 0, 1, 0, 0);
      step("rw_wipe1", Z, 0, 0, 1, 0);
      rst = 1'b1; dbg_req = 1'b0;
      step("rw_rst", Z, 0, 0, 0, 0);
      rst = 1'b0;
      step("rw_empty", Z, 1, 0, 0, 0);

      // EMPTY with a request goes straight to DEBUG.
      dbg_req = 1'b1;
      step("ed_req", Z, 0, 0, 0, 0);
      key_in = K3; key_valid = 1'b1;
      step("ed_debug", Z, 0, 0, 0, 1);
      key_valid = 1'b0; dbg_req = 1'b0;
      step("ed_drop", Z, 0, 0, 0, 1);
      step("ed_empty", Z, 1, 0, 0, 0);

`ifdef KDG_AUTH_EN
      // Request without authorisation keeps the key armed.
      key_in = K1; key_valid = 1'b1; dbg_auth_ok = 1'b0;
      step("au_load", Z, 1, 0, 0, 0);
      key_valid = 1'b0; dbg_req = 1'b1;
      for (int i = 0; i < 3; i++) step($sformatf("au_noauth%0d", i), K1, 1, 1, 0, 0);
      dbg_auth_ok = 1'b1;
      step("au_go", K1, 0, 1, 0, 0);
      for (int i = 1; i <= 4; i++) step($sformatf("au_wipe%0d", i), Z, 0, 0, 1, 0);
      step("au_verify", Z, 0, 0, 1, 0);
      dbg_auth_ok = 1'b0;
      step("au_debug_c6", Z, 0, 0, 0, 1);
      step("au_auth_low", Z, 0, 0, 0, 1);
      dbg_req = 1'b0;
      step("au_drop", Z, 0, 0, 0, 1);
      step("au_empty", Z, 1, 0, 0, 0);
`endif

      tick();
      tick();
      if (q.size() != 0) begin
         n_miss += q.size();
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
